// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use stalls, ID branch flushes, mult/div freeze.
// Optional HAZ_PERF_EN adds saturating stall/flush/multi-cycle performance counters.
module pipe_hazard_ctrl #(
   parameter int MC_CYCLES = 4,
   parameter int CNT_W     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       ex_memread,
   input  logic [4:0] ex_rt,
   input  logic       br_taken,
   input  logic       jump,
   input  logic       mc_start,
   output logic       pc_hold,
   output logic       ifid_hold,
   output logic       ifid_flush,
   output logic       idex_bubble,
   output logic       idex_hold,
   output logic       exmem_bubble,
   output logic       busy
`ifdef HAZ_PERF_EN
   ,
   output logic [15:0] stall_cyc,
   output logic [15:0] flush_cnt,
   output logic [15:0] mc_cyc
`endif
);

   typedef enum logic [0:0] {RUN = 1'b0, MC_WAIT = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_use_s;

   // Load in EX targets a source register of the ID instruction; $0 is never a real dependency.
   assign load_use_s = ex_memread && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   // State and wait-counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and Mealy control outputs; reset forces every control low.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pc_hold      = 1'b0;
      ifid_hold    = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      idex_hold    = 1'b0;
      exmem_bubble = 1'b0;
      busy         = 1'b0;
      case (state_q)
         RUN: begin
            if (load_use_s) begin
               // Branch resolution waits: its operand is the load result.
               pc_hold     = 1'b1;
               ifid_hold   = 1'b1;
               idex_bubble = 1'b1;
            end else if (br_taken || jump) begin
               ifid_flush = 1'b1;
            end else begin
               ifid_flush = 1'b0;
            end
            if (mc_start && (MC_CYCLES > 1)) begin
               state_d = MC_WAIT;
               cnt_d   = CNT_W'(MC_CYCLES - 1);
            end else begin
               state_d = RUN;
            end
         end
         MC_WAIT: begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
            busy         = 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
      if (reset) begin
         pc_hold      = 1'b0;
         ifid_hold    = 1'b0;
         ifid_flush   = 1'b0;
         idex_bubble  = 1'b0;
         idex_hold    = 1'b0;
         exmem_bubble = 1'b0;
         busy         = 1'b0;
      end else begin
         busy = busy;
      end
   end

`ifdef HAZ_PERF_EN
   logic [15:0] stall_cyc_q, stall_cyc_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;
   logic [15:0] mc_cyc_q, mc_cyc_d;

   // Saturating event counters; idex_bubble is only raised by a load-use stall.
   always_comb begin
      stall_cyc_d = stall_cyc_q;
      flush_cnt_d = flush_cnt_q;
      mc_cyc_d    = mc_cyc_q;
      if (idex_bubble && (stall_cyc_q != 16'hFFFF)) begin
         stall_cyc_d = stall_cyc_q + 16'd1;
      end else begin
         stall_cyc_d = stall_cyc_q;
      end
      if (ifid_flush && (flush_cnt_q != 16'hFFFF)) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
      if (busy && (mc_cyc_q != 16'hFFFF)) begin
         mc_cyc_d = mc_cyc_q + 16'd1;
      end else begin
         mc_cyc_d = mc_cyc_q;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cyc_q <= 16'd0;
         flush_cnt_q <= 16'd0;
         mc_cyc_q    <= 16'd0;
      end else begin
         stall_cyc_q <= stall_cyc_d;
         flush_cnt_q <= flush_cnt_d;
         mc_cyc_q    <= mc_cyc_d;
      end
   end

   assign stall_cyc = stall_cyc_q;
   assign flush_cnt = flush_cnt_q;
   assign mc_cyc    = mc_cyc_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, hand sequences, random vs. reference model.
module tb_pipe_hazard_ctrl;
   localparam int MC = 4;

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       memread;
      logic [4:0] ex_rt;
      logic       br;
      logic       jmp;
      logic       mc;
   } vec_t;

   typedef struct {
      vec_t       v;
      logic [6:0] exp;
   } tv_t;

   // {pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold, exmem_bubble, busy}
   localparam logic [6:0] O_IDLE  = 7'b0000000;
   localparam logic [6:0] O_STALL = 7'b1101000;
   localparam logic [6:0] O_FLUSH = 7'b0010000;
   localparam logic [6:0] O_WAIT  = 7'b1100111;

   logic clk, reset;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic id_uses_rt, ex_memread, br_taken, jump, mc_start;
   logic pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold, exmem_bubble, busy;
`ifdef HAZ_PERF_EN
   logic [15:0] stall_cyc, flush_cnt, mc_cyc;
`endif

   int total = 0;
   int bad   = 0;
   int freeze_left = 0;

   pipe_hazard_ctrl #(.MC_CYCLES(MC), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rt(ex_rt), .br_taken(br_taken), .jump(jump),
      .mc_start(mc_start), .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .idex_hold(idex_hold), .exmem_bubble(exmem_bubble), .busy(busy)
`ifdef HAZ_PERF_EN
      , .stall_cyc(stall_cyc), .flush_cnt(flush_cnt), .mc_cyc(mc_cyc)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                               input logic mr, input logic [4:0] er, input logic br,
                               input logic jmp, input logic mc);
      vec_t v;
      v.rs = rs; v.rt = rt; v.uses_rt = ur; v.memread = mr; v.ex_rt = er;
      v.br = br; v.jmp = jmp; v.mc = mc;
      return v;
   endfunction

   // Reference: outputs follow from the pending freeze length and the hazard rules.
   function automatic logic [6:0] model_exp(input vec_t v, input logic rst);
      logic lu;
      if (rst) return O_IDLE;
      if (freeze_left > 0) return O_WAIT;
      lu = v.memread && (v.ex_rt != 5'd0) &&
           ((v.ex_rt == v.rs) || (v.uses_rt && (v.ex_rt == v.rt)));
      if (lu) return O_STALL;
      if (v.br || v.jmp) return O_FLUSH;
      return O_IDLE;
   endfunction

   task automatic model_advance(input vec_t v, input logic rst);
      if (rst) freeze_left = 0;
      else if (freeze_left > 0) freeze_left = freeze_left - 1;
      else if (v.mc && (MC > 1)) freeze_left = MC - 1;
   endtask

   function automatic logic [6:0] outs();
      return {pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold, exmem_bubble, busy};
   endfunction

   task automatic check(input logic [6:0] exp, input string name);
      total++;
      if (outs() !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, outs(), exp);
      end
      total++;
      if (ifid_hold && ifid_flush) begin
         bad++;
         $display("FAIL %s_hold_flush: got hold=1 flush=1 want not both", name);
      end
   endtask

   task automatic drive(input vec_t v);
      id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt; ex_memread = v.memread;
      ex_rt = v.ex_rt; br_taken = v.br; jump = v.jmp; mc_start = v.mc;
   endtask

   // One cycle: drive after negedge, sample 1 ns later, then let the model step.
   task automatic cyc(input vec_t v, input logic [6:0] exp, input string name);
      @(negedge clk);
      drive(v);
      #1;
      check(exp, name);
      model_advance(v, reset);
   endtask

   vec_t idle_v;
   tv_t  tbl[10];

   initial begin
      idle_v = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      tbl[0] = '{idle_v, O_IDLE};
      tbl[1] = '{mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0), O_STALL};
      tbl[2] = '{mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), O_IDLE};
      tbl[3] = '{mk(5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0), O_IDLE};
      tbl[4] = '{mk(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0), O_STALL};
      tbl[5] = '{mk(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), O_FLUSH};
      tbl[6] = '{mk(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0), O_FLUSH};
      tbl[7] = '{mk(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0), O_STALL};
      tbl[8] = '{mk(5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0), O_IDLE};
      tbl[9] = '{mk(5'd9, 5'd31, 1'b1, 1'b1, 5'd31, 1'b0, 1'b1, 1'b0), O_STALL};

      // Reset with active-looking inputs: all outputs must stay low.
      reset = 1'b1;
      drive(mk(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1));
      cyc(mk(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1), O_IDLE, "reset_c1");
      cyc(mk(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1), O_IDLE, "reset_c2");
      @(negedge clk);
      reset = 1'b0;
      drive(idle_v);
      #1;
      check(O_IDLE, "idle_after_reset");

      foreach (tbl[i]) cyc(tbl[i].v, tbl[i].exp, $sformatf("tbl%0d", i));

      // Load-use lasts one cycle once the bubble clears ex_memread.
      cyc(tbl[1].v, O_STALL, "lu_stall");
      cyc(mk(5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), O_IDLE, "lu_release");

      // Load-use masks a branch; the branch flushes on the following cycle.
      cyc(tbl[7].v, O_STALL, "lu_br_stall");
      cyc(mk(5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), O_FLUSH, "lu_br_flush");
      cyc(idle_v, O_IDLE, "lu_br_idle");

      // Multi-cycle op: 3 frozen cycles, jump during wait ignored.
      cyc(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1), O_IDLE, "mc_start");
      cyc(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1), O_WAIT, "mc_w1");
      cyc(mk(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0), O_WAIT, "mc_w2");
      cyc(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0), O_WAIT, "mc_w3");
      cyc(idle_v, O_IDLE, "mc_done");

      // mc_start together with a taken branch still flushes on the start cycle.
      cyc(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1), O_FLUSH, "mc_br_start");
      cyc(idle_v, O_WAIT, "mc_br_w1");
      cyc(idle_v, O_WAIT, "mc_br_w2");
      cyc(idle_v, O_WAIT, "mc_br_w3");
      cyc(tbl[5].v, O_FLUSH, "mc_br_after");

      // Asynchronous reset in the 2nd wait cycle.
      cyc(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1), O_IDLE, "rmw_start");
      cyc(idle_v, O_WAIT, "rmw_w1");
      cyc(idle_v, O_WAIT, "rmw_w2");
      reset = 1'b1;
      #1;
      check(O_IDLE, "rmw_async");
      model_advance(idle_v, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check(O_IDLE, "rmw_release");
      cyc(idle_v, O_IDLE, "rmw_no_residual");
      cyc(tbl[1].v, O_STALL, "rmw_run_lu");

      // Random traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         vec_t v;
         logic [6:0] e;
         v.rs      = 5'($urandom_range(0, 3));
         v.rt      = 5'($urandom_range(0, 3));
         v.uses_rt = 1'($urandom_range(0, 1));
         v.memread = 1'($urandom_range(0, 1));
         v.ex_rt   = 5'($urandom_range(0, 3));
         v.br      = ($urandom_range(0, 3) == 0);
         v.jmp     = ($urandom_range(0, 5) == 0);
         v.mc      = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         reset = ($urandom_range(0, 63) == 0);
         drive(v);
         #1;
         e = model_exp(v, reset);
         check(e, $sformatf("rand%0d", n));
         model_advance(v, reset);
      end

`ifdef HAZ_PERF_EN
      @(negedge clk);
      reset = 1'b1;
      drive(idle_v);
      #1;
      model_advance(idle_v, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      cyc(tbl[1].v, O_STALL, "perf_lu1");
      cyc(idle_v, O_IDLE, "perf_gap");
      cyc(tbl[4].v, O_STALL, "perf_lu2");
      cyc(tbl[5].v, O_FLUSH, "perf_flush");
      cyc(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1), O_IDLE, "perf_mc");
      cyc(idle_v, O_WAIT, "perf_w1");
      cyc(idle_v, O_WAIT, "perf_w2");
      cyc(idle_v, O_WAIT, "perf_w3");
      cyc(idle_v, O_IDLE, "perf_end");
      total++;
      if ({stall_cyc, flush_cnt, mc_cyc} !== {16'd2, 16'd1, 16'd3}) begin
         bad++;
         $display("FAIL perf_counts: got %0d/%0d/%0d want 2/1/3", stall_cyc, flush_cnt, mc_cyc);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
